seg7_scan_driver: RTL and testbench

//  Parametrised multi-digit 7-segment driver with time-multiplexed anodes.

---
 rtl/seg7_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : multiplexed multi-digit 7-segment driver, frame-safe load
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int HEX_EN     = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  blank_lz,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic [DIGITS-1:0]     load_dp,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_tick
);

   localparam int              CNT_W    = $clog2(SCAN_DIV);
   localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic            POL      = (ACTIVE_LOW != 0);
   localparam logic            HEX_ON   = (HEX_EN != 0);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] active_q, active_d;
   logic [DIGITS-1:0]   active_dp_q, active_dp_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                pending_q, pending_d;
   logic                frame_tick_q, frame_tick_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                tick;
   logic                fe;
   logic                accept;
   logic [DIGITS-1:0]   lz_blank;
   logic                all_zero;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [DIGITS-1:0]   cur_an;
   logic [6:0]          dec_seg;

   assign tick       = (cnt_q == CNT_LAST);
   assign fe         = tick && (idx_q == IDX_LAST);
   assign load_ready = !pending_q;
   assign accept     = load_valid && !pending_q;

   // Scan divider and digit index run regardless of en.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Shadow/active hand-over; a load accepted on fe itself waits for the next fe.
   always_comb begin
      active_d    = active_q;
      active_dp_d = active_dp_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      if (fe && pending_q) begin
         active_d    = shadow_q;
         active_dp_d = shadow_dp_q;
         pending_d   = 1'b0;
      end
      if (accept) begin
         shadow_d    = load_data;
         shadow_dp_d = load_dp;
         pending_d   = 1'b1;
      end
      frame_tick_d = fe;
   end

   // lz_blank[k]: nibbles k..DIGITS-1 are all zero (digit 0 never qualifies).
   always_comb begin
      lz_blank = '0;
      all_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero    = all_zero && (active_q[4*k +: 4] == 4'h0);
         lz_blank[k] = all_zero;
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_an    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = active_q[4*i +: 4];
            cur_dp    = active_dp_q[i];
            cur_blank = blank_lz && lz_blank[i];
            cur_an[i] = 1'b1;
         end
      end
   end

   always_comb begin
      dec_seg = 7'h00;
      case (cur_nib)
         4'h0: dec_seg = 7'h3F;
         4'h1: dec_seg = 7'h06;
         4'h2: dec_seg = 7'h5B;
         4'h3: dec_seg = 7'h4F;
         4'h4: dec_seg = 7'h66;
         4'h5: dec_seg = 7'h6D;
         4'h6: dec_seg = 7'h7D;
         4'h7: dec_seg = 7'h07;
         4'h8: dec_seg = 7'h7F;
         4'h9: dec_seg = 7'h6F;
         4'hA: dec_seg = HEX_ON ? 7'h77 : 7'h00;
         4'hB: dec_seg = HEX_ON ? 7'h7C : 7'h00;
         4'hC: dec_seg = HEX_ON ? 7'h39 : 7'h00;
         4'hD: dec_seg = HEX_ON ? 7'h5E : 7'h00;
         4'hE: dec_seg = HEX_ON ? 7'h79 : 7'h00;
         4'hF: dec_seg = HEX_ON ? 7'h71 : 7'h00;
         default: dec_seg = 7'h00;
      endcase
   end

   // Output registers hold active-high values; a blanked digit keeps its anode.
   always_comb begin
      seg_d = 7'h00;
      dp_d  = 1'b0;
      an_d  = '0;
      if (en) begin
         an_d = cur_an;
         if (!cur_blank) begin
            seg_d = dec_seg;
            dp_d  = cur_dp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         active_q     <= '0;
         active_dp_q  <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         seg_q        <= 7'h00;
         dp_q         <= 1'b0;
         an_q         <= '0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         active_dp_q  <= active_dp_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame_tick_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg_out    = seg_q ^ {7{POL}};
   assign dp_out     = dp_q ^ POL;
   assign an_out     = an_q ^ {DIGITS{POL}};
   assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (hex/active-high and no-hex/active-low)
// share stimulus and are compared each cycle against a time-based reference model.
`default_nettype none

module tb_seg7_scan_driver;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, blank_lz, load_valid;
   logic [15:0] load_data;
   logic [3:0]  load_dp;
   logic        load_ready_a, load_ready_b;
   logic [6:0]  seg_out_a, seg_out_b;
   logic        dp_out_a, dp_out_b;
   logic [3:0]  an_out_a, an_out_b;
   logic        frame_tick_a, frame_tick_b;

   seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(1), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz), .load_valid(load_valid),
      .load_ready(load_ready_a), .load_data(load_data), .load_dp(load_dp),
      .seg_out(seg_out_a), .dp_out(dp_out_a), .an_out(an_out_a), .frame_tick(frame_tick_a));

   seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(0), .ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz), .load_valid(load_valid),
      .load_ready(load_ready_b), .load_data(load_data), .load_dp(load_dp),
      .seg_out(seg_out_b), .dp_out(dp_out_b), .an_out(an_out_b), .frame_tick(frame_tick_b));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: position in the scan follows from cycles since reset.
   int          t = 0;
   bit          m_init = 1'b0;
   logic [15:0] m_active, m_shadow;
   logic [3:0]  m_active_dp, m_shadow_dp;
   bit          m_pending;
   logic [6:0]  e_seg_a, e_seg_b;
   logic        e_dp;
   logic [3:0]  e_an;
   bit          e_ft;

   function automatic logic [6:0] seg_of(input logic [3:0] n, input bit hex);
      if (n > 4'd9 && !hex) return 7'h00;
      return SEG_TAB[n];
   endfunction

   task automatic step();
      int         idx, cnt;
      bit         fe, acc, blank;
      logic [3:0] nib;
      logic [6:0] sa, sb;
      logic       d;
      logic [3:0] an;
      if (m_init) begin
         check("ready_a", 32'(load_ready_a), 32'(!m_pending));
         check("ready_b", 32'(load_ready_b), 32'(!m_pending));
      end
      cnt   = t % SCAN_DIV;
      idx   = (t / SCAN_DIV) % DIGITS;
      fe    = (cnt == SCAN_DIV - 1) && (idx == DIGITS - 1);
      acc   = load_valid && !m_pending;
      nib   = m_active[4*idx +: 4];
      blank = blank_lz && (idx > 0) && ((m_active >> (4*idx)) == 16'h0);
      sa    = (!en || blank) ? 7'h00 : seg_of(nib, 1'b1);
      sb    = (!en || blank) ? 7'h00 : seg_of(nib, 1'b0);
      d     = (!en || blank) ? 1'b0 : m_active_dp[idx];
      an    = en ? 4'(1 << idx) : 4'h0;
      @(posedge clk);
      if (rst) begin
         t = 0; m_init = 1'b1;
         m_active = '0; m_shadow = '0; m_active_dp = '0; m_shadow_dp = '0;
         m_pending = 1'b0;
         e_seg_a = '0; e_seg_b = '0; e_dp = 1'b0; e_an = '0; e_ft = 1'b0;
      end else begin
         e_seg_a = sa; e_seg_b = sb; e_dp = d; e_an = an; e_ft = fe;
         if (fe && m_pending) begin
            m_active = m_shadow; m_active_dp = m_shadow_dp; m_pending = 1'b0;
         end
         if (acc) begin
            m_shadow = load_data; m_shadow_dp = load_dp; m_pending = 1'b1;
         end
         t++;
      end
      #1;
      if (m_init) begin
         check("seg_a", 32'(seg_out_a), 32'(e_seg_a));
         check("seg_b", 32'(seg_out_b), 32'(e_seg_b ^ 7'h7F));
         check("dp_a",  32'(dp_out_a),  32'(e_dp));
         check("dp_b",  32'(dp_out_b),  32'(!e_dp));
         check("an_a",  32'(an_out_a),  32'(e_an));
         check("an_b",  32'(an_out_b),  32'(e_an ^ 4'hF));
         check("ft_a",  32'(frame_tick_a), 32'(e_ft));
         check("ft_b",  32'(frame_tick_b), 32'(e_ft));
      end
   endtask

   function automatic logic [15:0] rand_data();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++)
         if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b1; blank_lz = 1'b0; load_valid = 1'b0;
      load_data = '0; load_dp = '0;
      repeat (3) step();
      rst = 1'b0;

      // Plain decimal load, then hex digits with leading-zero blanking.
      load_valid = 1'b1; load_data = 16'h1234; step(); load_valid = 1'b0;
      repeat (40) step();
      blank_lz = 1'b1; load_valid = 1'b1; load_data = 16'h00A5; load_dp = 4'h5; step();
      load_valid = 1'b0; repeat (40) step();

      // Held valid while the shadow is full.
      load_valid = 1'b1; load_data = 16'h0A0A; step();
      load_data = 16'h0B0B; repeat (40) step();
      load_valid = 1'b0; repeat (20) step();

      // Accept exactly in the frame-end cycle.
      while ((t % 16) != 15) step();
      load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'h9; step();
      load_valid = 1'b0; repeat (40) step();

      // Enable dropped mid-scan.
      repeat (5) step();
      en = 1'b0; repeat (7) step(); en = 1'b1; repeat (20) step();

      // Reset with a pending load.
      load_valid = 1'b1; load_data = 16'h9999; step(); load_valid = 1'b0;
      rst = 1'b1; step(); rst = 1'b0; repeat (40) step();

      repeat (2500) begin
         rst        = ($urandom_range(0, 299) == 0);
         en         = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         load_valid = ($urandom_range(0, 5) == 0);
         load_data  = rand_data();
         load_dp    = 4'($urandom_range(0, 15));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
